fir_dec_cfg_ctrl: RTL and testbench

- Configuration sequencer for the per-channel FIR decimator.
- Accepts decimation-ratio writes from the register bank and applies each one only at a decimation-group boundary, or after a timeout.
- Drives the decimator's mode and cfg_rst, then blanks its output for a settle period before reopening the output path.
- Sits between the register interface and the decimator instance, one controller per decimator.

---
 rtl/fir_dec_cfg_ctrl_if.sv | 28 ++
 rtl/fir_dec_cfg_ctrl.sv | 155 +++++++++++++++
 tb/tb_fir_dec_cfg_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_dec_cfg_ctrl_if.sv
// Signal bundle between the register bank / decimator and the FIR decimator
// configuration sequencer. The sequencer connects through the slave modport;
// the surrounding logic (register bank plus decimator) uses the master side.
`timescale 1ns/1ps
interface fir_dec_cfg_ctrl_if;
  logic       cfg_wr;
  logic [5:0] cfg_mode;
  logic       cfg_ovr_clr;
  logic       din_valid;
  logic       dec_dout_valid;
  logic [5:0] dec_mode;
  logic       dec_cfg_rst;
  logic       dout_valid_gated;
  logic       busy;
  logic       cfg_done;
  logic       cfg_ovr;
  logic [1:0] state_o;

  modport master (
    output cfg_wr, cfg_mode, cfg_ovr_clr, din_valid, dec_dout_valid,
    input  dec_mode, dec_cfg_rst, dout_valid_gated, busy, cfg_done, cfg_ovr, state_o
  );

  modport slave (
    input  cfg_wr, cfg_mode, cfg_ovr_clr, din_valid, dec_dout_valid,
    output dec_mode, dec_cfg_rst, dout_valid_gated, busy, cfg_done, cfg_ovr, state_o
  );
endinterface

// File: rtl/fir_dec_cfg_ctrl.sv
// Configuration sequencer for one FIR decimator channel. A new decimation
// mode is held until the decimator finishes its current group (or a timeout
// expires), then applied together with a cfg_rst pulse. The decimator output
// is blanked for a number of samples afterwards so downstream logic never sees
// samples from a half-flushed filter.
`timescale 1ns/1ps
module fir_dec_cfg_ctrl #(
  parameter logic [5:0]  DEF_MODE    = 6'd0,
  parameter int unsigned CFG_RST_LEN = 2,
  parameter int unsigned SETTLE_SMP  = 4,
  parameter logic [15:0] TIMEOUT_CYC = 16'd4096
) (
  input logic               sys_clk,
  input logic               sys_rst_n,
  fir_dec_cfg_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_BND = 2'd1,
    CFG_RST  = 2'd2,
    SETTLE   = 2'd3
  } state_t;

  localparam logic [3:0]  RST_LAST = 4'(CFG_RST_LEN - 1);
  localparam logic [15:0] SMP_LAST = 16'(SETTLE_SMP - 1);
  localparam logic [15:0] TMO_LAST = TIMEOUT_CYC - 16'd1;

  state_t      state;
  logic [5:0]  dec_mode;
  logic        dec_cfg_rst;
  logic        gate_open;
  logic        cfg_done;
  logic        cfg_ovr;
  logic        pend_flag;
  logic [5:0]  pend_mode;
  logic [5:0]  phase;
  logic [15:0] tmo_cnt;
  logic [3:0]  rst_cnt;
  logic [15:0] smp_cnt;

  logic bnd_hit;
  logic tmo_hit;
  logic ovr_set;

  // Last sample of the current group is being consumed this cycle.
  assign bnd_hit = bus.din_valid && (phase == dec_mode);
  assign tmo_hit = (TIMEOUT_CYC != 16'd0) && (tmo_cnt == TMO_LAST);
  // A second write while one is already queued behind a running sequence.
  assign ovr_set = bus.cfg_wr && pend_flag && ((state == CFG_RST) || (state == SETTLE));

  // Mirror of the decimator's sample counter, used to find group boundaries.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      phase <= 6'd0;
    end else if (dec_cfg_rst) begin
      phase <= 6'd0;
    end else if (bus.din_valid) begin
      phase <= (phase == dec_mode) ? 6'd0 : phase + 6'd1;
    end
  end

  // Sequencer: wait for boundary, pulse cfg_rst, blank settle samples.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= RUN;
      dec_mode    <= DEF_MODE;
      dec_cfg_rst <= 1'b0;
      gate_open   <= 1'b1;
      cfg_done    <= 1'b0;
      cfg_ovr     <= 1'b0;
      pend_flag   <= 1'b0;
      pend_mode   <= DEF_MODE;
      tmo_cnt     <= 16'd0;
      rst_cnt     <= 4'd0;
      smp_cnt     <= 16'd0;
    end else begin
      cfg_done <= 1'b0;
      if (bus.cfg_wr) begin
        pend_mode <= bus.cfg_mode;
      end
      // A set in the same cycle wins over the software clear.
      if (ovr_set) begin
        cfg_ovr <= 1'b1;
      end else if (bus.cfg_ovr_clr) begin
        cfg_ovr <= 1'b0;
      end
      unique case (state)
        RUN: begin
          // A fresh write and a queued one both start a new sequence.
          if (bus.cfg_wr || pend_flag) begin
            state     <= WAIT_BND;
            tmo_cnt   <= 16'd0;
            pend_flag <= 1'b0;
          end
        end
        WAIT_BND: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (bnd_hit || tmo_hit) begin
            state       <= CFG_RST;
            // A write landing on the exit cycle is the latest and still wins.
            dec_mode    <= bus.cfg_wr ? bus.cfg_mode : pend_mode;
            dec_cfg_rst <= 1'b1;
            gate_open   <= 1'b0;
            pend_flag   <= 1'b0;
            rst_cnt     <= 4'd0;
          end
        end
        CFG_RST: begin
          if (bus.cfg_wr) begin
            pend_flag <= 1'b1;
          end
          if (rst_cnt == RST_LAST) begin
            dec_cfg_rst <= 1'b0;
            smp_cnt     <= 16'd0;
            if (SETTLE_SMP == 0) begin
              state     <= RUN;
              gate_open <= 1'b1;
              cfg_done  <= 1'b1;
            end else begin
              state <= SETTLE;
            end
          end else begin
            rst_cnt <= rst_cnt + 4'd1;
          end
        end
        SETTLE: begin
          if (bus.cfg_wr) begin
            pend_flag <= 1'b1;
          end
          // The closing pulse is still blanked: gate_open rises after it.
          if (bus.dec_dout_valid) begin
            if (smp_cnt == SMP_LAST) begin
              state     <= RUN;
              gate_open <= 1'b1;
              cfg_done  <= 1'b1;
            end else begin
              smp_cnt <= smp_cnt + 16'd1;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.dec_mode         = dec_mode;
  assign bus.dec_cfg_rst      = dec_cfg_rst;
  assign bus.dout_valid_gated = bus.dec_dout_valid & gate_open;
  assign bus.busy             = (state != RUN);
  assign bus.cfg_done         = cfg_done;
  assign bus.cfg_ovr          = cfg_ovr;
  assign bus.state_o          = state;

endmodule

// File: tb/tb_fir_dec_cfg_ctrl.sv
// Bench for fir_dec_cfg_ctrl: three controllers with different settings share
// one directed stimulus stream; each is compared every cycle against its own
// behavioural model, and key points are pinned with hand-computed values.
`timescale 1ns/1ps
module tb_fir_dec_cfg_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [5:0] cfg_mode = 6'd0;
  logic       cfg_ovr_clr = 1'b0;
  logic       din_valid = 1'b0;
  logic       dec_dout_valid = 1'b0;

  int nvec = 0;
  int nerr = 0;

  always #5 sys_clk = ~sys_clk;

  fir_dec_cfg_ctrl_if ia ();
  fir_dec_cfg_ctrl_if ib ();
  fir_dec_cfg_ctrl_if ic ();

  assign ia.cfg_wr = cfg_wr;  assign ia.cfg_mode = cfg_mode;  assign ia.cfg_ovr_clr = cfg_ovr_clr;
  assign ia.din_valid = din_valid;  assign ia.dec_dout_valid = dec_dout_valid;
  assign ib.cfg_wr = cfg_wr;  assign ib.cfg_mode = cfg_mode;  assign ib.cfg_ovr_clr = cfg_ovr_clr;
  assign ib.din_valid = din_valid;  assign ib.dec_dout_valid = dec_dout_valid;
  assign ic.cfg_wr = cfg_wr;  assign ic.cfg_mode = cfg_mode;  assign ic.cfg_ovr_clr = cfg_ovr_clr;
  assign ic.din_valid = din_valid;  assign ic.dec_dout_valid = dec_dout_valid;

  // A: normal settle, short timeout.  B: timeout disabled.  C: no settle, longer cfg_rst.
  fir_dec_cfg_ctrl #(.DEF_MODE(6'd0), .CFG_RST_LEN(2), .SETTLE_SMP(4), .TIMEOUT_CYC(16'd16))
    u_a (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(ia));
  fir_dec_cfg_ctrl #(.DEF_MODE(6'd0), .CFG_RST_LEN(2), .SETTLE_SMP(4), .TIMEOUT_CYC(16'd0))
    u_b (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(ib));
  fir_dec_cfg_ctrl #(.DEF_MODE(6'd0), .CFG_RST_LEN(3), .SETTLE_SMP(0), .TIMEOUT_CYC(16'd16))
    u_c (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(ic));

  // Behavioural model: st 0=running, 1=waiting for boundary, 2=in cfg reset,
  // 3=blanking. 'left' counts down remaining reset cycles / blanked samples.
  typedef struct packed {
    int st;
    int mode;
    int phase;
    int pmode;
    int pend;
    int ovr;
    int gate;
    int done;
    int wt;
    int left;
  } mdl_t;

  mdl_t ma, mb, mc;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m = '0;
    m.gate = 1;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int len, int smp, int tmo,
                                    int wr, int wm, int clr, int dv, int ddv);
    mdl_t n;
    int ovr_now;
    n = m;
    n.done = 0;
    ovr_now = 0;
    if (wr != 0) n.pmode = wm;
    if (m.st == 2) n.phase = 0;
    else if (dv != 0) n.phase = (m.phase + 1) % (m.mode + 1);
    case (m.st)
      0: if (wr != 0 || m.pend != 0) begin
        n.st = 1; n.wt = 0; n.pend = 0;
      end
      1: begin
        n.wt = m.wt + 1;
        if ((dv != 0 && m.phase == m.mode) || (tmo != 0 && m.wt + 1 == tmo)) begin
          n.st = 2; n.mode = n.pmode; n.gate = 0; n.left = len; n.pend = 0;
        end
      end
      2: begin
        if (wr != 0) begin ovr_now = m.pend; n.pend = 1; end
        n.left = m.left - 1;
        if (n.left == 0) begin
          if (smp == 0) begin n.st = 0; n.gate = 1; n.done = 1; end
          else begin n.st = 3; n.left = smp; end
        end
      end
      default: begin
        if (wr != 0) begin ovr_now = m.pend; n.pend = 1; end
        if (ddv != 0) begin
          n.left = m.left - 1;
          if (n.left == 0) begin n.st = 0; n.gate = 1; n.done = 1; end
        end
      end
    endcase
    if (ovr_now != 0) n.ovr = 1;
    else if (clr != 0) n.ovr = 0;
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input string tag, input mdl_t m, input logic [5:0] mode,
                          input logic crst, input logic gated, input logic busy,
                          input logic done, input logic ovr, input logic [1:0] st);
    chk({tag, ".dec_mode"}, 32'(mode), 32'(m.mode));
    chk({tag, ".dec_cfg_rst"}, 32'(crst), (m.st == 2) ? 32'd1 : 32'd0);
    chk({tag, ".dout_valid_gated"}, 32'(gated), (dec_dout_valid && m.gate != 0) ? 32'd1 : 32'd0);
    chk({tag, ".busy"}, 32'(busy), (m.st != 0) ? 32'd1 : 32'd0);
    chk({tag, ".cfg_done"}, 32'(done), 32'(m.done));
    chk({tag, ".cfg_ovr"}, 32'(ovr), 32'(m.ovr));
    chk({tag, ".state_o"}, 32'(st), 32'(m.st));
  endtask

  // Advance the three models on the same edge the DUTs sample.
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ma = mdl_reset(); mb = mdl_reset(); mc = mdl_reset();
    end else begin
      ma = mdl_step(ma, 2, 4, 16, int'(cfg_wr), int'(cfg_mode), int'(cfg_ovr_clr), int'(din_valid), int'(dec_dout_valid));
      mb = mdl_step(mb, 2, 4, 0,  int'(cfg_wr), int'(cfg_mode), int'(cfg_ovr_clr), int'(din_valid), int'(dec_dout_valid));
      mc = mdl_step(mc, 3, 0, 16, int'(cfg_wr), int'(cfg_mode), int'(cfg_ovr_clr), int'(din_valid), int'(dec_dout_valid));
    end
  end

  // Compare every DUT output against its model away from the active edge.
  always @(negedge sys_clk) begin
    if (sys_rst_n === 1'b1) begin
      cmp_inst("A", ma, ia.dec_mode, ia.dec_cfg_rst, ia.dout_valid_gated, ia.busy, ia.cfg_done, ia.cfg_ovr, ia.state_o);
      cmp_inst("B", mb, ib.dec_mode, ib.dec_cfg_rst, ib.dout_valid_gated, ib.busy, ib.cfg_done, ib.cfg_ovr, ib.state_o);
      cmp_inst("C", mc, ic.dec_mode, ic.dec_cfg_rst, ic.dout_valid_gated, ic.busy, ic.cfg_done, ic.cfg_ovr, ic.state_o);
    end
  end

  task automatic cyc(input logic wr, input logic [5:0] md, input logic clr, input logic dv, input logic ddv);
    cfg_wr = wr; cfg_mode = md; cfg_ovr_clr = clr; din_valid = dv; dec_dout_valid = ddv;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst.state", 32'(ia.state_o), 32'd0);
    chk("rst.dec_mode", 32'(ia.dec_mode), 32'd0);
    chk("rst.cfg_rst", 32'(ia.dec_cfg_rst), 32'd0);
    chk("rst.busy", 32'(ia.busy), 32'd0);
    chk("rst.cfg_ovr", 32'(ia.cfg_ovr), 32'd0);
    @(negedge sys_clk); #2;
    sys_rst_n = 1'b1;

    // Mode 0 -> 3: with mode 0 every sample is a boundary.
    cyc(1'b1, 6'd3, 1'b0, 1'b1, 1'b0);
    chk("s1.wait", 32'(ia.state_o), 32'd1);
    chk("s1.busy", 32'(ia.busy), 32'd1);
    cyc(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    chk("s1.cfgrst_state", 32'(ia.state_o), 32'd2);
    chk("s1.mode", 32'(ia.dec_mode), 32'd3);
    chk("s1.cfgrst_hi", 32'(ia.dec_cfg_rst), 32'd1);
    idle(1);
    chk("s1.cfgrst_2nd", 32'(ia.dec_cfg_rst), 32'd1);
    idle(1);
    chk("s1.settle", 32'(ia.state_o), 32'd3);
    chk("s1.cfgrst_lo", 32'(ia.dec_cfg_rst), 32'd0);
    chk("s1.C_cfgrst_3rd", 32'(ic.dec_cfg_rst), 32'd1);
    pulses(1);
    chk("s1.C_run", 32'(ic.state_o), 32'd0);
    chk("s1.C_done", 32'(ic.cfg_done), 32'd1);
    pulses(2);
    chk("s1.still_settle", 32'(ia.state_o), 32'd3);
    pulses(1);
    chk("s1.run", 32'(ia.state_o), 32'd0);
    chk("s1.done", 32'(ia.cfg_done), 32'd1);
    idle(1);
    chk("s1.done_1cyc", 32'(ia.cfg_done), 32'd0);

    // Same mode rewritten, din_valid every cycle from phase 0: boundary at 4th sample.
    cyc(1'b1, 6'd3, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    chk("s2.wait_3rd", 32'(ia.state_o), 32'd1);
    cyc(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    chk("s2.cfgrst_4th", 32'(ia.dec_cfg_rst), 32'd1);
    idle(2);
    chk("s2.settle", 32'(ia.state_o), 32'd3);
    pulses(4);
    chk("s2.done", 32'(ia.cfg_done), 32'd1);

    // No din_valid: timeout after exactly 16 waiting cycles (B never leaves).
    idle(2);
    cyc(1'b1, 6'd2, 1'b0, 1'b0, 1'b0);
    idle(15);
    chk("s3.wait_15", 32'(ia.state_o), 32'd1);
    idle(1);
    chk("s3.tmo_cfgrst", 32'(ia.state_o), 32'd2);
    chk("s3.mode", 32'(ia.dec_mode), 32'd2);
    chk("s3.B_wait", 32'(ib.state_o), 32'd1);
    idle(2);
    pulses(4);
    idle(10);
    chk("s3.B_wait_long", 32'(ib.state_o), 32'd1);

    // Three writes while waiting: last one wins, no overrun.
    cyc(1'b1, 6'd5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 6'd7, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 6'd9, 1'b0, 1'b0, 1'b0);
    idle(13);
    chk("s4.wait", 32'(ia.state_o), 32'd1);
    idle(1);
    chk("s4.cfgrst", 32'(ia.state_o), 32'd2);
    chk("s4.mode", 32'(ia.dec_mode), 32'd9);
    chk("s4.ovr", 32'(ia.cfg_ovr), 32'd0);
    idle(2);
    pulses(4);
    chk("s4.done", 32'(ia.cfg_done), 32'd1);
    idle(1);

    // Writes 7 then 8 during settle: overrun, then 8 applied in a second pass.
    cyc(1'b1, 6'd1, 1'b0, 1'b0, 1'b0);
    idle(16);
    chk("s5.cfgrst", 32'(ia.state_o), 32'd2);
    chk("s5.mode1", 32'(ia.dec_mode), 32'd1);
    idle(2);
    chk("s5.settle", 32'(ia.state_o), 32'd3);
    cyc(1'b1, 6'd7, 1'b0, 1'b0, 1'b0);
    chk("s5.ovr_first", 32'(ia.cfg_ovr), 32'd0);
    cyc(1'b1, 6'd8, 1'b0, 1'b0, 1'b0);
    chk("s5.ovr_set", 32'(ia.cfg_ovr), 32'd1);
    pulses(4);
    chk("s5.run", 32'(ia.state_o), 32'd0);
    chk("s5.done", 32'(ia.cfg_done), 32'd1);
    idle(1);
    chk("s5.rewait", 32'(ia.state_o), 32'd1);
    idle(15);
    chk("s5.rewait_15", 32'(ia.state_o), 32'd1);
    idle(1);
    chk("s5.cfgrst2", 32'(ia.state_o), 32'd2);
    chk("s5.mode8", 32'(ia.dec_mode), 32'd8);
    idle(2);
    pulses(4);
    chk("s5.done2", 32'(ia.cfg_done), 32'd1);
    cyc(1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
    chk("s5.ovr_clr", 32'(ia.cfg_ovr), 32'd0);

    // Mode 5 applied, reset asserted mid-settle.
    cyc(1'b1, 6'd5, 1'b0, 1'b0, 1'b0);
    idle(18);
    chk("s6.settle", 32'(ia.state_o), 32'd3);
    chk("s6.mode5", 32'(ia.dec_mode), 32'd5);
    cyc(1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
    #3;
    sys_rst_n = 1'b0;
    #1;
    chk("s6.rst_mode", 32'(ia.dec_mode), 32'd0);
    chk("s6.rst_state", 32'(ia.state_o), 32'd0);
    chk("s6.rst_busy", 32'(ia.busy), 32'd0);
    chk("s6.rst_cfgrst", 32'(ia.dec_cfg_rst), 32'd0);
    chk("s6.rst_gate", 32'(ia.dout_valid_gated), 32'd1);
    chk("s6.rst_B_state", 32'(ib.state_o), 32'd0);
    @(negedge sys_clk); #2;
    sys_rst_n = 1'b1;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
